// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - decode-to-EX bundle carrying ID inputs, pipeline controls and ID/EX register outputs
interface id_ex_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  reg_write_id;
    logic                  mem_to_reg_id;
    logic                  mem_read_id;
    logic                  mem_write_id;
    logic                  branch_id;
    logic                  alu_src_id;
    logic                  reg_dst_id;
    logic [1:0]            alu_op_id;
    logic [5:0]            func_id;
    logic [DATA_W-1:0]     rd1_id;
    logic [DATA_W-1:0]     rd2_id;
    logic [DATA_W-1:0]     imm_id;
    logic [REG_ADDR_W-1:0] rs_id;
    logic [REG_ADDR_W-1:0] rt_id;
    logic [REG_ADDR_W-1:0] rd_id;
    logic                  ext_stall;
    logic                  flush;

    logic                  reg_write_id_ex;
    logic                  mem_to_reg_id_ex;
    logic                  mem_read_id_ex;
    logic                  mem_write_id_ex;
    logic                  branch_id_ex;
    logic                  alu_src_id_ex;
    logic                  reg_dst_id_ex;
    logic [1:0]            alu_op_id_ex;
    logic [5:0]            func_id_ex;
    logic [DATA_W-1:0]     rd1_id_ex;
    logic [DATA_W-1:0]     rd2_id_ex;
    logic [DATA_W-1:0]     imm_id_ex;
    logic [REG_ADDR_W-1:0] rs_id_ex;
    logic [REG_ADDR_W-1:0] rt_id_ex;
    logic [REG_ADDR_W-1:0] rd_id_ex;
    logic                  valid_id_ex;
    logic                  hazard_stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id, branch_id,
               alu_src_id, reg_dst_id, alu_op_id, func_id, rd1_id, rd2_id, imm_id,
               rs_id, rt_id, rd_id, ext_stall, flush,
        input  reg_write_id_ex, mem_to_reg_id_ex, mem_read_id_ex, mem_write_id_ex,
               branch_id_ex, alu_src_id_ex, reg_dst_id_ex, alu_op_id_ex, func_id_ex,
               rd1_id_ex, rd2_id_ex, imm_id_ex, rs_id_ex, rt_id_ex, rd_id_ex,
               valid_id_ex, hazard_stall, stall_count
    );

    modport slave (
        input  reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id, branch_id,
               alu_src_id, reg_dst_id, alu_op_id, func_id, rd1_id, rd2_id, imm_id,
               rs_id, rt_id, rd_id, ext_stall, flush,
        output reg_write_id_ex, mem_to_reg_id_ex, mem_read_id_ex, mem_write_id_ex,
               branch_id_ex, alu_src_id_ex, reg_dst_id_ex, alu_op_id_ex, func_id_ex,
               rd1_id_ex, rd2_id_ex, imm_id_ex, rs_id_ex, rt_id_ex, rd_id_ex,
               valid_id_ex, hazard_stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and stall counter
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic                  reg_dst;
        logic [1:0]            alu_op;
        logic [5:0]            func;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard;

    // Only a real load writing a non-zero register can starve the next instruction.
    assign hazard = stage_q.mem_read && stage_q.valid && (stage_q.rt != '0) &&
                    ((stage_q.rt == bus.rs_id) || (stage_q.rt == bus.rt_id));

    always_comb begin
        stage_d       = stage_q;
        stall_count_d = stall_count_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.ext_stall) begin
            stage_d = stage_q;
        end else if (hazard) begin
            // All-zero bubble decodes as a side-effect-free add.
            stage_d = '0;
            if (stall_count_q != {CNT_W{1'b1}}) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end else begin
            stage_d.valid      = 1'b1;
            stage_d.reg_write  = bus.reg_write_id;
            stage_d.mem_to_reg = bus.mem_to_reg_id;
            stage_d.mem_read   = bus.mem_read_id;
            stage_d.mem_write  = bus.mem_write_id;
            stage_d.branch     = bus.branch_id;
            stage_d.alu_src    = bus.alu_src_id;
            stage_d.reg_dst    = bus.reg_dst_id;
            stage_d.alu_op     = bus.alu_op_id;
            stage_d.func       = bus.func_id;
            stage_d.rd1        = bus.rd1_id;
            stage_d.rd2        = bus.rd2_id;
            stage_d.imm        = bus.imm_id;
            stage_d.rs         = bus.rs_id;
            stage_d.rt         = bus.rt_id;
            stage_d.rd         = bus.rd_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q       <= '0;
            stall_count_q <= '0;
        end else begin
            stage_q       <= stage_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.hazard_stall     = hazard && !bus.flush;
    assign bus.stall_count      = stall_count_q;
    assign bus.valid_id_ex      = stage_q.valid;
    assign bus.reg_write_id_ex  = stage_q.reg_write;
    assign bus.mem_to_reg_id_ex = stage_q.mem_to_reg;
    assign bus.mem_read_id_ex   = stage_q.mem_read;
    assign bus.mem_write_id_ex  = stage_q.mem_write;
    assign bus.branch_id_ex     = stage_q.branch;
    assign bus.alu_src_id_ex    = stage_q.alu_src;
    assign bus.reg_dst_id_ex    = stage_q.reg_dst;
    assign bus.alu_op_id_ex     = stage_q.alu_op;
    assign bus.func_id_ex       = stage_q.func;
    assign bus.rd1_id_ex        = stage_q.rd1;
    assign bus.rd2_id_ex        = stage_q.rd2;
    assign bus.imm_id_ex        = stage_q.imm;
    assign bus.rs_id_ex         = stage_q.rs;
    assign bus.rt_id_ex         = stage_q.rt;
    assign bus.rd_id_ex         = stage_q.rd;
endmodule
